// File: rtl/vtiming_ctrl.sv
// Vertical timing sequencer: counts scanlines on hreset and produces vcnt,
// vreset, blank/sync strobes and a frame counter, all registered in mclk.
module vtiming_ctrl #(
  parameter int unsigned V_TOTAL     = 262,
  parameter int unsigned VSYNC_START = 4,
  parameter int unsigned VSYNC_END   = 8,
  parameter int unsigned VBLANK_END  = 16
) (
  input  logic       mclk,
  input  logic       reset,
  input  logic       hreset,
  output logic [8:0] vcnt,
  output logic       vreset,
  output logic       vblank,
  output logic       _vblank,
  output logic       _vsync,
  output logic       frame_strb,
  output logic [7:0] frame_cnt
);

  localparam int unsigned CNT_W  = 9;
  localparam int unsigned FCNT_W = 8;

  localparam logic [CNT_W-1:0] LINE_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] LINE_VS_ON  = CNT_W'(VSYNC_START);
  localparam logic [CNT_W-1:0] LINE_VS_OFF = CNT_W'(VSYNC_END);
  localparam logic [CNT_W-1:0] LINE_VB_OFF = CNT_W'(VBLANK_END);
  localparam bit               SKIP_POST   = (VSYNC_END == VBLANK_END);

  if (!(VSYNC_START > 0 && VSYNC_START < VSYNC_END && VSYNC_END <= VBLANK_END &&
        VBLANK_END < V_TOTAL && V_TOTAL <= 511)) begin : g_param_check
    $error("vtiming_ctrl: illegal vertical timing parameters");
  end

  typedef enum logic [1:0] {
    ST_BLANK  = 2'd0,
    ST_SYNC   = 2'd1,
    ST_POST   = 2'd2,
    ST_ACTIVE = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    vcnt_q, vcnt_d;
  logic                vreset_q, vreset_d;
  logic                vblank_q, vblank_d;
  logic                vblank_n_q, vblank_n_d;
  logic                vsync_n_q, vsync_n_d;
  logic                strb_q, strb_d;
  logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
  logic                line_wrap;

  // Line counter; any count at or past the last line wraps, covering corrupt values.
  always_comb begin
    line_wrap = hreset && (vcnt_q >= LINE_LAST);
    vcnt_d    = vcnt_q;
    if (hreset) begin
      vcnt_d = line_wrap ? '0 : vcnt_q + CNT_W'(1);
    end
  end

  // Sequencing FSM and output decode, both taken from the next-state count so
  // every output moves on the same edge as vcnt.
  always_comb begin
    state_d    = state_q;
    vreset_d   = 1'b0;
    vblank_d   = 1'b1;
    vblank_n_d = 1'b0;
    vsync_n_d  = 1'b1;
    strb_d     = 1'b0;
    fcnt_d     = fcnt_q;

    if (hreset) begin
      if (line_wrap) begin
        state_d = ST_BLANK;
      end else begin
        unique case (state_q)
          ST_BLANK: if (vcnt_d == LINE_VS_ON)  state_d = ST_SYNC;
          ST_SYNC:  if (vcnt_d == LINE_VS_OFF) state_d = SKIP_POST ? ST_ACTIVE : ST_POST;
          ST_POST:  if (vcnt_d == LINE_VB_OFF) state_d = ST_ACTIVE;
          default:  state_d = state_q;
        endcase
      end
    end

    vreset_d   = (vcnt_d == LINE_LAST);
    vblank_d   = (state_d != ST_ACTIVE);
    vblank_n_d = (state_d == ST_ACTIVE);
    vsync_n_d  = (state_d != ST_SYNC);
    strb_d     = line_wrap;
    if (line_wrap) begin
      fcnt_d = fcnt_q + FCNT_W'(1);
    end
  end

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_BLANK;
      vcnt_q     <= '0;
      vreset_q   <= 1'b0;
      vblank_q   <= 1'b1;
      vblank_n_q <= 1'b0;
      vsync_n_q  <= 1'b1;
      strb_q     <= 1'b0;
      fcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      vcnt_q     <= vcnt_d;
      vreset_q   <= vreset_d;
      vblank_q   <= vblank_d;
      vblank_n_q <= vblank_n_d;
      vsync_n_q  <= vsync_n_d;
      strb_q     <= strb_d;
      fcnt_q     <= fcnt_d;
    end
  end

  assign vcnt       = vcnt_q;
  assign vreset     = vreset_q;
  assign vblank     = vblank_q;
  assign _vblank    = vblank_n_q;
  assign _vsync     = vsync_n_q;
  assign frame_strb = strb_q;
  assign frame_cnt  = fcnt_q;

endmodule

// File: tb/tb_vtiming_ctrl.sv
// Bench for vtiming_ctrl: default timing instance plus a POST-skipping instance
// (VSYNC_END == VBLANK_END == 8) driven by the same clock, reset and hreset.
module tb_vtiming_ctrl;

  logic       mclk = 1'b0;
  logic       reset = 1'b1;
  logic       hreset = 1'b0;

  logic [8:0] vcnt, b_vcnt;
  logic       vreset, vblank, vblank_n, vsync_n, frame_strb;
  logic       b_vreset, b_vblank, b_vblank_n, b_vsync_n, b_frame_strb;
  logic [7:0] frame_cnt, b_frame_cnt;

  vtiming_ctrl dut (
    .mclk(mclk), .reset(reset), .hreset(hreset),
    .vcnt(vcnt), .vreset(vreset), .vblank(vblank), ._vblank(vblank_n),
    ._vsync(vsync_n), .frame_strb(frame_strb), .frame_cnt(frame_cnt)
  );

  vtiming_ctrl #(.V_TOTAL(262), .VSYNC_START(4), .VSYNC_END(8), .VBLANK_END(8)) dut_b (
    .mclk(mclk), .reset(reset), .hreset(hreset),
    .vcnt(b_vcnt), .vreset(b_vreset), .vblank(b_vblank), ._vblank(b_vblank_n),
    ._vsync(b_vsync_n), .frame_strb(b_frame_strb), .frame_cnt(b_frame_cnt)
  );

  always #5 mclk = ~mclk;

  typedef struct packed {
    logic [8:0] vcnt;
    logic       vreset, vblank, vblank_n, vsync_n, strb;
    logic [7:0] fcnt;
    logic [8:0] b_vcnt;
    logic       b_vreset, b_vblank, b_vblank_n, b_vsync_n, b_strb;
    logic [7:0] b_fcnt;
  } obs_t;

  typedef struct {
    int         pulses;
    logic [8:0] vcnt;
    logic       vblank;
    logic       vsync_n;
    logic       vreset;
    logic [7:0] fcnt;
    logic       b_vblank;
  } vec_t;

  int   total = 0;
  int   bad = 0;
  obs_t sb[$];

  int   m_line = 0;
  int   m_fcnt = 0;
  int   strb_seen = 0, vs_falls = 0, vb_falls = 0, b_vb_falls = 0;
  logic prev_vs = 1'b1, prev_vb = 1'b1, prev_bvb = 1'b1;

  function automatic obs_t model_obs(int line, logic strb, int fc);
    obs_t o;
    o.vcnt       = 9'(line);
    o.vreset     = (line == 261);
    o.vblank     = (line < 16);
    o.vblank_n   = !(line < 16);
    o.vsync_n    = !(line >= 4 && line < 8);
    o.strb       = strb;
    o.fcnt       = 8'(fc);
    o.b_vcnt     = 9'(line);
    o.b_vreset   = (line == 261);
    o.b_vblank   = (line < 8);
    o.b_vblank_n = !(line < 8);
    o.b_vsync_n  = !(line >= 4 && line < 8);
    o.b_strb     = strb;
    o.b_fcnt     = 8'(fc);
    return o;
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o = {vcnt, vreset, vblank, vblank_n, vsync_n, frame_strb, frame_cnt,
         b_vcnt, b_vreset, b_vblank, b_vblank_n, b_vsync_n, b_frame_strb, b_frame_cnt};
    return o;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One mclk cycle: drive hreset, push the model's expectation, compare after the edge.
  task automatic step(input logic h);
    obs_t exp_o, got;
    logic strb;
    @(negedge mclk);
    hreset = h;
    strb = 1'b0;
    if (h) begin
      if (m_line == 261) begin
        m_line = 0;
        m_fcnt = (m_fcnt + 1) % 256;
        strb = 1'b1;
      end else begin
        m_line = m_line + 1;
      end
    end
    sb.push_back(model_obs(m_line, strb, m_fcnt));
    @(posedge mclk);
    #1;
    exp_o = sb.pop_front();
    got = dut_obs();
    check("cycle", 64'(got), 64'(exp_o));
    if (frame_strb) strb_seen++;
    if (prev_vs && !vsync_n) vs_falls++;
    if (prev_vb && !vblank) vb_falls++;
    if (prev_bvb && !b_vblank) b_vb_falls++;
    prev_vs = vsync_n;
    prev_vb = vblank;
    prev_bvb = b_vblank;
  endtask

  task automatic clear_counts();
    strb_seen = 0; vs_falls = 0; vb_falls = 0; b_vb_falls = 0;
    prev_vs = 1'b1; prev_vb = 1'b1; prev_bvb = 1'b1;
  endtask

  task automatic apply_reset();
    @(negedge mclk);
    reset = 1'b1;
    hreset = 1'b0;
    m_line = 0;
    m_fcnt = 0;
    repeat (2) @(posedge mclk);
    #1;
    check("reset_state", 64'(dut_obs()), 64'(model_obs(0, 1'b0, 0)));
    @(negedge mclk);
    reset = 1'b0;
    clear_counts();
  endtask

  initial begin
    vec_t vecs[10];
    int   pulses;
    vecs[0] = '{3,   9'd3,   1'b1, 1'b1, 1'b0, 8'd0, 1'b1};
    vecs[1] = '{4,   9'd4,   1'b1, 1'b0, 1'b0, 8'd0, 1'b1};
    vecs[2] = '{7,   9'd7,   1'b1, 1'b0, 1'b0, 8'd0, 1'b1};
    vecs[3] = '{8,   9'd8,   1'b1, 1'b1, 1'b0, 8'd0, 1'b0};
    vecs[4] = '{15,  9'd15,  1'b1, 1'b1, 1'b0, 8'd0, 1'b0};
    vecs[5] = '{16,  9'd16,  1'b0, 1'b1, 1'b0, 8'd0, 1'b0};
    vecs[6] = '{100, 9'd100, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0};
    vecs[7] = '{260, 9'd260, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0};
    vecs[8] = '{261, 9'd261, 1'b0, 1'b1, 1'b1, 8'd0, 1'b0};
    vecs[9] = '{262, 9'd0,   1'b1, 1'b1, 1'b0, 8'd1, 1'b1};

    // Frame walk with hreset every 4 mclk, checkpointed by the vector table.
    apply_reset();
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      while (pulses < vecs[i].pulses) begin
        step(1'b1);
        step(1'b0);
        step(1'b0);
        step(1'b0);
        pulses++;
      end
      check($sformatf("vec%0d", i),
            64'({vcnt, vblank, vblank_n, vsync_n, vreset, frame_cnt, b_vblank}),
            64'({vecs[i].vcnt, vecs[i].vblank, !vecs[i].vblank, vecs[i].vsync_n,
                 vecs[i].vreset, vecs[i].fcnt, vecs[i].b_vblank}));
    end
    check("walk_strobes", 64'(strb_seen), 64'd1);

    // Back-to-back hreset for two frames.
    apply_reset();
    repeat (524) step(1'b1);
    check("b2b_strobes", 64'(strb_seen), 64'd2);
    check("b2b_frame_cnt", 64'(frame_cnt), 64'd2);
    check("b2b_vsync_entries", 64'(vs_falls), 64'd2);
    check("b2b_active_entries", 64'(vb_falls), 64'd2);
    check("b2b_skip_active_entries", 64'(b_vb_falls), 64'd2);

    // Asynchronous reset in the middle of the active region.
    repeat (100) step(1'b1);
    check("pre_reset_line", 64'({vcnt, vblank, frame_cnt}), 64'({9'd100, 1'b0, 8'd2}));
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", 64'({vcnt, vblank, vsync_n, frame_cnt, frame_strb, vreset}),
          64'({9'd0, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0}));
    m_line = 0;
    m_fcnt = 0;

    // 256 frames: frame counter wraps with a strobe on the wrap.
    apply_reset();
    repeat (255 * 262) step(1'b1);
    check("fcnt_255", 64'(frame_cnt), 64'd255);
    clear_counts();
    repeat (262) step(1'b1);
    check("fcnt_wrap", 64'({frame_cnt, frame_strb}), 64'({8'd0, 1'b1}));
    check("wrap_strobes", 64'(strb_seen), 64'd1);
    check("skip_fcnt_wrap", 64'(b_frame_cnt), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
